// File: rtl/pipe_control.sv
// Pipeline control for a D/EX/MEM/WB integer pipeline: decode, stage control registers, load-use stall and branch/jump flush.
// Define PIPE_CONTROL_MULTDIV_EN to hold mul/div in EX for MD_LAT cycles.
module pipe_control #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              d_valid,
  input  logic [4:0]        opcode,
  input  logic [4:0]        aluop_in,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic              br_taken,
  output logic              ex_valid,
  output logic [4:0]        ex_aluop,
  output logic              ex_alu_inb,
  output logic              ex_br,
  output logic              ex_jp,
  output logic              mem_valid,
  output logic              mem_dmwe,
  output logic              wb_valid,
  output logic              wb_rwe,
  output logic              wb_rwd,
  output logic [REG_AW-1:0] wb_rd,
  output logic              stall,
  output logic              flush
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [REG_AW-1:0] LINK_REG = {REG_AW{1'b1}};
  localparam logic [REG_AW-1:0] EXC_REG  = {{(REG_AW-1){1'b1}}, 1'b0};

  if (MD_LAT < 2 || MD_LAT > 32) begin : g_bad_md_lat
    $error("pipe_control: MD_LAT must be in 2..32");
  end

  typedef struct packed {
    logic              valid;
    logic [4:0]        aluop;
    logic              alu_inb;
    logic              br;
    logic              jp;
    logic              dmwe;
    logic              rwe;
    logic              rwd;
    logic [REG_AW-1:0] dest;
  } ex_ctrl_t;

  typedef struct packed {
    logic              valid;
    logic              dmwe;
    logic              rwe;
    logic              rwd;
    logic [REG_AW-1:0] dest;
  } mem_ctrl_t;

  typedef struct packed {
    logic              valid;
    logic              rwe;
    logic              rwd;
    logic [REG_AW-1:0] dest;
  } wb_ctrl_t;

  ex_ctrl_t  dec;
  ex_ctrl_t  ex_q, ex_d;
  mem_ctrl_t mem_q, mem_d;
  wb_ctrl_t  wb_q, wb_d;
  logic      load_use;
  logic      md_busy;

  // Decode; an absent instruction decodes straight to a bubble.
  always_comb begin
    dec = '0;
    case (opcode)
      OP_RTYPE: begin
        dec.aluop = aluop_in;
        dec.rwe   = 1'b1;
        dec.dest  = rd;
      end
      OP_ADDI: begin
        dec.alu_inb = 1'b1;
        dec.rwe     = 1'b1;
        dec.dest    = rd;
      end
      OP_SW: begin
        dec.alu_inb = 1'b1;
        dec.dmwe    = 1'b1;
      end
      OP_LW: begin
        dec.alu_inb = 1'b1;
        dec.rwe     = 1'b1;
        dec.rwd     = 1'b1;
        dec.dest    = rd;
      end
      OP_BNE, OP_BLT, OP_BEX: begin
        dec.aluop = 5'b00001;
        dec.br    = 1'b1;
      end
      OP_J, OP_JR: dec.jp = 1'b1;
      OP_JAL: begin
        dec.jp   = 1'b1;
        dec.rwe  = 1'b1;
        dec.dest = LINK_REG;
      end
      OP_SETX: begin
        dec.rwe  = 1'b1;
        dec.dest = EXC_REG;
      end
      default: ;
    endcase
    if (dec.dest == '0) dec.rwe = 1'b0;
    dec.valid = 1'b1;
    if (!d_valid) dec = '0;
  end

  // rwd is set only by lw, so it doubles as the "EX holds a load" flag. A load never
  // branches or jumps, so flush and load_use are mutually exclusive by construction and
  // flush wins without any path from br_taken into stall.
  assign load_use = d_valid && ex_q.valid && ex_q.rwd && (ex_q.dest != '0) &&
                    ((ex_q.dest == rs) || (ex_q.dest == rt));
  assign flush    = ex_q.valid && (ex_q.jp || (ex_q.br && br_taken));
  assign stall    = load_use || md_busy;

  always_comb begin
    ex_d  = dec;
    mem_d = '{valid: ex_q.valid, dmwe: ex_q.dmwe, rwe: ex_q.rwe, rwd: ex_q.rwd, dest: ex_q.dest};
    wb_d  = '{valid: mem_q.valid, rwe: mem_q.rwe, rwd: mem_q.rwd, dest: mem_q.dest};
    if (md_busy) begin
      ex_d  = ex_q;
      mem_d = '0;
    end else if (load_use || flush) begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef PIPE_CONTROL_MULTDIV_EN
  localparam int MD_CW = $clog2(MD_LAT);

  logic [MD_CW-1:0] md_cnt_q, md_cnt_d;
  logic             dec_is_md;

  assign dec_is_md = d_valid && (opcode == OP_RTYPE) &&
                     ((aluop_in == 5'b00110) || (aluop_in == 5'b00111));
  assign md_busy   = (md_cnt_q != '0);

  // Loaded only when the mul/div actually enters EX; counts the extra EX cycles.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_busy) md_cnt_d = md_cnt_q - 1'b1;
    else if (dec_is_md && !load_use && !flush) md_cnt_d = MD_CW'(MD_LAT - 1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) md_cnt_q <= '0;
    else          md_cnt_q <= md_cnt_d;
  end
`else
  assign md_busy = 1'b0;
`endif

  assign ex_valid   = ex_q.valid;
  assign ex_aluop   = ex_q.aluop;
  assign ex_alu_inb = ex_q.alu_inb;
  assign ex_br      = ex_q.br;
  assign ex_jp      = ex_q.jp;
  assign mem_valid  = mem_q.valid;
  assign mem_dmwe   = mem_q.dmwe;
  assign wb_valid   = wb_q.valid;
  assign wb_rwe     = wb_q.rwe;
  assign wb_rwd     = wb_q.rwd;
  assign wb_rd      = wb_q.dest;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: reset, load-use stall, flush, writeback controls and mul/div hold.
module tb_pipe_control;
  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BAD   = 5'b11111;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              d_valid;
  logic [4:0]        opcode;
  logic [4:0]        aluop_in;
  logic [REG_AW-1:0] rs, rt, rd;
  logic              br_taken;
  logic              ex_valid;
  logic [4:0]        ex_aluop;
  logic              ex_alu_inb, ex_br, ex_jp;
  logic              mem_valid, mem_dmwe;
  logic              wb_valid, wb_rwe, wb_rwd;
  logic [REG_AW-1:0] wb_rd;
  logic              stall, flush;
  logic [31:0]       all_outs;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipe_control #(.REG_AW(REG_AW), .MD_LAT(MD_LAT)) dut (
    .clock(clock), .reset_n(reset_n), .d_valid(d_valid), .opcode(opcode),
    .aluop_in(aluop_in), .rs(rs), .rt(rt), .rd(rd), .br_taken(br_taken),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_alu_inb(ex_alu_inb),
    .ex_br(ex_br), .ex_jp(ex_jp), .mem_valid(mem_valid), .mem_dmwe(mem_dmwe),
    .wb_valid(wb_valid), .wb_rwe(wb_rwe), .wb_rwd(wb_rwd), .wb_rd(wb_rd),
    .stall(stall), .flush(flush)
  );

  assign all_outs = {11'd0, ex_valid, ex_aluop, ex_alu_inb, ex_br, ex_jp, mem_valid,
                     mem_dmwe, wb_valid, wb_rwe, wb_rwd, wb_rd, stall, flush};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] alu,
                       input int s, input int t, input int d);
    d_valid  = v;
    opcode   = op;
    aluop_in = alu;
    rs       = REG_AW'(s);
    rt       = REG_AW'(t);
    rd       = REG_AW'(d);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    br_taken = 1'b0;
    drive(1'b1, OP_LW, 5'd0, 0, 0, 5);
    repeat (3) begin
      tick();
      chk("reset_outputs", all_outs, 32'd0);
    end
    reset_n = 1'b1;
    #1;
    chk("release_ex_empty", 32'(ex_valid), 32'd0);

    // lw rd=5 enters EX one cycle after release
    tick();
    chk("lw_ex_valid", 32'(ex_valid), 32'd1);
    chk("lw_ex_inb", 32'(ex_alu_inb), 32'd1);
    drive(1'b1, OP_RTYPE, 5'd0, 5, 1, 6);
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_no_flush", 32'(flush), 32'd0);
    tick();
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_stall_once", 32'(stall), 32'd0);
    chk("lu_lw_in_mem", 32'(mem_valid), 32'd1);
    tick();
    chk("add_ex_valid", 32'(ex_valid), 32'd1);
    chk("add_ex_inb", 32'(ex_alu_inb), 32'd0);
    chk("lw_wb_ctrl", 32'({wb_valid, wb_rwe, wb_rwd}), 32'd7);
    chk("lw_wb_rd", 32'(wb_rd), 32'd5);

    // taken bne flushes the younger instruction
    drive(1'b1, OP_BNE, 5'd0, 1, 2, 0);
    tick();
    br_taken = 1'b1;
    drive(1'b1, OP_ADDI, 5'd0, 0, 0, 8);
    chk("bne_ex_ctrl", 32'({ex_br, ex_aluop}), 32'h21);
    chk("bne_flush", 32'(flush), 32'd1);
    chk("bne_no_stall", 32'(stall), 32'd0);
    tick();
    br_taken = 1'b0;
    drive(1'b1, OP_JAL, 5'd0, 0, 0, 7);
    chk("flush_bubble", 32'(ex_valid), 32'd0);
    chk("flush_clear", 32'(flush), 32'd0);

    // jal writes r31, addi to r0 never writes
    tick();
    drive(1'b0, OP_RTYPE, 5'd0, 0, 0, 0);
    chk("jal_ex_jp", 32'(ex_jp), 32'd1);
    chk("jal_flush", 32'(flush), 32'd1);
    tick();
    drive(1'b1, OP_ADDI, 5'd0, 0, 0, 0);
    tick();
    drive(1'b0, OP_RTYPE, 5'd0, 0, 0, 0);
    chk("jal_wb_valid", 32'(wb_valid), 32'd1);
    chk("jal_wb_rwe", 32'(wb_rwe), 32'd1);
    chk("jal_wb_rd", 32'(wb_rd), 32'd31);
    tick();
    tick();
    chk("addi_r0_wb_valid", 32'(wb_valid), 32'd1);
    chk("addi_r0_wb_rwe", 32'(wb_rwe), 32'd0);

    // taken branch in EX, lw rd=3 in D, then dependent add
    drive(1'b1, OP_BNE, 5'd0, 1, 2, 0);
    tick();
    br_taken = 1'b1;
    drive(1'b1, OP_LW, 5'd0, 0, 0, 3);
    chk("flush_vs_lu_flush", 32'(flush), 32'd1);
    chk("flush_vs_lu_stall", 32'(stall), 32'd0);
    tick();
    br_taken = 1'b0;
    drive(1'b1, OP_RTYPE, 5'd0, 3, 0, 4);
    chk("flushed_lw_no_stall", 32'(stall), 32'd0);
    chk("flushed_lw_bubble", 32'(ex_valid), 32'd0);
    tick();
    chk("add_after_flush_ex", 32'(ex_valid), 32'd1);

    // sw store enable in MEM, setx writes r30, not-taken branch
    drive(1'b1, OP_SW, 5'd0, 1, 2, 0);
    tick();
    drive(1'b1, OP_SETX, 5'd0, 0, 0, 0);
    tick();
    drive(1'b1, OP_BNE, 5'd0, 1, 2, 0);
    chk("sw_mem_dmwe", 32'(mem_dmwe), 32'd1);
    tick();
    drive(1'b1, OP_BAD, 5'd0, 0, 0, 9);
    chk("bne_not_taken", 32'(flush), 32'd0);
    tick();
    drive(1'b1, OP_RTYPE, 5'b00110, 1, 2, 9);
    chk("setx_wb_rwe", 32'(wb_rwe), 32'd1);
    chk("setx_wb_rd", 32'(wb_rd), 32'd30);
    chk("bad_op_ex_valid", 32'(ex_valid), 32'd1);
    chk("bad_op_ex_ctrl", 32'({ex_aluop, ex_alu_inb, ex_br, ex_jp}), 32'd0);

    // mul enters EX, add waits behind it
    tick();
    drive(1'b1, OP_RTYPE, 5'd0, 1, 2, 10);
`ifdef PIPE_CONTROL_MULTDIV_EN
    chk("md_stall_0", 32'(stall), 32'd1);
    tick();
    chk("md_stall_1", 32'(stall), 32'd1);
    chk("md_mem_bubble_1", 32'(mem_valid), 32'd0);
    tick();
    chk("md_stall_2", 32'(stall), 32'd1);
    chk("md_mem_bubble_2", 32'(mem_valid), 32'd0);
    tick();
    chk("md_stall_end", 32'(stall), 32'd0);
    chk("md_mem_bubble_3", 32'(mem_valid), 32'd0);
    chk("md_ex_hold", 32'(ex_aluop), 32'd6);
    tick();
    chk("md_add_ex_aluop", 32'(ex_aluop), 32'd0);
    chk("md_add_ex_valid", 32'(ex_valid), 32'd1);
    chk("md_mul_mem", 32'(mem_valid), 32'd1);
`else
    chk("mul_no_stall", 32'(stall), 32'd0);
    chk("mul_ex_aluop", 32'(ex_aluop), 32'd6);
    tick();
    chk("mul_add_ex_aluop", 32'(ex_aluop), 32'd0);
    chk("mul_add_ex_valid", 32'(ex_valid), 32'd1);
    chk("mul_in_mem", 32'(mem_valid), 32'd1);
`endif

    // div in EX, reset asserted mid-flight
    drive(1'b1, OP_RTYPE, 5'b00111, 1, 2, 11);
    tick();
    drive(1'b0, OP_RTYPE, 5'd0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_outputs", all_outs, 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    tick();
    chk("post_reset_empty", 32'(ex_valid), 32'd0);
    chk("post_reset_no_stall", 32'(stall), 32'd0);
    drive(1'b1, OP_RTYPE, 5'd0, 1, 2, 12);
    tick();
    chk("post_reset_ex", 32'(ex_valid), 32'd1);
    chk("post_reset_stall", 32'(stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
